// File: rtl/rs_pkg.sv
// Shared Reed-Solomon RS(255,249) constants and GF(2^8) helpers used by
// both the encoder and the syndrome side of the link.
package rs_pkg;

   localparam int RS_N    = 255;
   localparam int RS_K    = 249;
   localparam int RS_NPAR = RS_N - RS_K;

   localparam logic [8:0] GF_POLY = 9'h11D;

   localparam logic [7:0] ALPHA_POW [8] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
   };

   typedef enum logic {
      IDLE,
      ACC
   } rs_state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ t;
         t = t[7] ? ({t[6:0], 1'b0} ^ GF_POLY[7:0]) : {t[6:0], 1'b0};
      end
      return p;
   endfunction

   // Small exponents come straight from the table; larger ones keep
   // multiplying by alpha from alpha^7.
   function automatic logic [7:0] gf_alpha_pow(input int e);
      int         r;
      logic [7:0] p;
      r = e % RS_N;
      if (r < 8) return ALPHA_POW[r[2:0]];
      p = ALPHA_POW[7];
      for (int k = 8; k <= r; k++) p = gf_mul(p, 8'h02);
      return p;
   endfunction

   // Generator g(x) = prod (x + alpha^(fcr+i)), packed {g6..g0}, g6 = 1.
   function automatic logic [8*(RS_NPAR+1)-1:0] rs_gen_poly(input int fcr);
      logic [7:0]                g [RS_NPAR+1];
      logic [7:0]                root;
      logic [8*(RS_NPAR+1)-1:0]  packed_g;
      for (int k = 0; k <= RS_NPAR; k++) g[k] = '0;
      g[0] = 8'h01;
      for (int i = 0; i < RS_NPAR; i++) begin
         root = gf_alpha_pow(fcr + i);
         for (int k = i + 1; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
         g[0] = gf_mul(g[0], root);
      end
      for (int k = 0; k <= RS_NPAR; k++) packed_g[8*k +: 8] = g[k];
      return packed_g;
   endfunction

endpackage

// File: rtl/rs_syndrome_multiply.sv
// Combinational GF(2^8) multiplier X = A * B modulo GF_POLY.
module multiply
   import rs_pkg::*;
(
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic [7:0] X
);

   logic [7:0] sh [8];

   // sh[k] = A * alpha^k; X sums the terms selected by the bits of B
   always_comb begin
      sh[0] = A;
      for (int k = 1; k < 8; k++) begin
         sh[k] = {sh[k-1][6:0], 1'b0} ^ (sh[k-1][7] ? GF_POLY[7:0] : 8'h00);
      end
      X = '0;
      for (int k = 0; k < 8; k++) begin
         if (B[k]) X = X ^ sh[k];
      end
   end

endmodule

// File: rtl/rs_syndrome.sv
// RS(255,249) syndrome calculator: Horner evaluation of the received block
// at alpha^(FCR+i), i = 0..5, one symbol per accepted cycle.
module rs_syndrome
   import rs_pkg::*;
#(
   parameter int FCR = 0,
   parameter int N   = RS_N
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic                  in_sop,
   input  logic [7:0]            in_sym,
   output logic                  busy,
   output logic                  syn_valid,
   output logic [8*RS_NPAR-1:0]  syn,
   output logic                  err_detect,
   output logic                  sop_err
);

   localparam logic [7:0] CNT_LAST = 8'(N - 1);

   rs_state_t            state, state_nxt;
   logic [7:0]           cnt;
   logic [7:0]           acc    [RS_NPAR];
   logic [7:0]           prod   [RS_NPAR];
   logic [7:0]           horner [RS_NPAR];
   logic [8*RS_NPAR-1:0] syn_nxt;
   logic                 load, step, done, restart;

   for (genvar i = 0; i < RS_NPAR; i++) begin : g_syn
      localparam logic [7:0] ROOT = gf_alpha_pow(FCR + i);
      multiply u_mul (
         .A (acc[i]),
         .B (ROOT),
         .X (prod[i])
      );
      assign horner[i]          = prod[i] ^ in_sym;
      assign syn_nxt[8*i +: 8] = horner[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      done      = 1'b0;
      restart   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_sop) begin
               load      = 1'b1;
               state_nxt = ACC;
            end
         end
         ACC: begin
            if (in_valid) begin
               if (in_sop) begin
                  load    = 1'b1;
                  restart = 1'b1;
               end else begin
                  step = 1'b1;
                  if (cnt == CNT_LAST) begin
                     done      = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output registers are separate from the accumulators, so a new block
   // can load in the same cycle the previous result is presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         syn        <= '0;
         syn_valid  <= 1'b0;
         err_detect <= 1'b0;
         sop_err    <= 1'b0;
         for (int k = 0; k < RS_NPAR; k++) acc[k] <= '0;
      end else begin
         syn_valid <= done;
         sop_err   <= restart;
         if (load) begin
            cnt <= 8'd1;
            for (int k = 0; k < RS_NPAR; k++) acc[k] <= in_sym;
         end else if (step) begin
            cnt <= done ? 8'd0 : cnt + 8'd1;
            for (int k = 0; k < RS_NPAR; k++) acc[k] <= horner[k];
         end
         if (done) begin
            syn        <= syn_nxt;
            err_detect <= |syn_nxt;
         end
      end
   end

   assign busy = (state == ACC) | syn_valid;

endmodule

// File: tb/tb_rs_syndrome.sv
// Scoreboard bench for rs_syndrome: expected syndromes come from direct
// polynomial evaluation, pulse timing from a cycle-level reference model.
module tb_rs_syndrome;

   localparam int FCR = 0;
   localparam int NB  = 255;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sop   = 1'b0;
   logic [7:0]  in_sym   = 8'h00;
   logic        busy;
   logic        syn_valid;
   logic [47:0] syn;
   logic        err_detect;
   logic        sop_err;

   rs_syndrome #(.FCR(FCR), .N(NB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sop     (in_sop),
      .in_sym     (in_sym),
      .busy       (busy),
      .syn_valid  (syn_valid),
      .syn        (syn),
      .err_detect (err_detect),
      .sop_err    (sop_err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [47:0] sb [$];
   logic [7:0]  blk  [NB];
   logic [7:0]  gexp [NB];

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] aa;
      logic [7:0] p;
      aa = {1'b0, a};
      p  = '0;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa[7:0];
         aa = aa << 1;
         if (aa[8]) aa = aa ^ 9'h11D;
      end
      return p;
   endfunction

   // S_i = sum_j blk[j] * alpha^((FCR+i) * (254-j)), evaluated term by term
   function automatic logic [47:0] eval_syn();
      logic [47:0] r;
      logic [7:0]  s;
      int          e;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         s = '0;
         for (int j = 0; j < NB; j++) begin
            e = ((FCR + i) * (NB - 1 - j)) % NB;
            s = s ^ tb_mul(blk[j], gexp[e]);
         end
         r[8*i +: 8] = s;
      end
      return r;
   endfunction

   task automatic encode_msg();
      logic [7:0] g [7];
      logic [7:0] r [6];
      logic [7:0] fb;
      logic [7:0] root;
      for (int k = 0; k < 7; k++) g[k] = '0;
      g[0] = 8'h01;
      for (int i = 0; i < 6; i++) begin
         root = gexp[FCR + i];
         for (int k = i + 1; k >= 1; k--) g[k] = g[k-1] ^ tb_mul(g[k], root);
         g[0] = tb_mul(g[0], root);
      end
      for (int k = 0; k < 6; k++) r[k] = '0;
      for (int j = 0; j < 249; j++) begin
         blk[j] = 8'(j + 1);
         fb = blk[j] ^ r[5];
         for (int k = 5; k >= 1; k--) r[k] = r[k-1] ^ tb_mul(fb, g[k]);
         r[0] = tb_mul(fb, g[0]);
      end
      for (int t = 0; t < 6; t++) blk[249 + t] = r[5 - t];
   endtask

   task automatic fill_blk(input logic [7:0] v);
      for (int j = 0; j < NB; j++) blk[j] = v;
   endtask

   task automatic fill_rand();
      for (int j = 0; j < NB; j++) blk[j] = 8'($urandom_range(0, 255));
   endtask

   task automatic send_sym(input logic [7:0] s, input logic sop);
      in_valid = 1'b1;
      in_sop   = sop;
      in_sym   = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_sym   = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_block(input int maxgap, input int nsym);
      for (int j = 0; j < nsym; j++) begin
         if (maxgap > 0) idle(int'($urandom_range(1, maxgap)));
         if (j == NB - 1) sb.push_back(eval_syn());
         send_sym(blk[j], j == 0);
      end
   endtask

   // Reference model, sampled on the falling edge away from DUT updates
   int          m_cnt  = 0;
   logic        exp_sv = 1'b0;
   logic        exp_se = 1'b0;
   logic        nsv, nse;
   logic [47:0] held = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_cnt  = 0;
         exp_sv = 1'b0;
         exp_se = 1'b0;
         held   = '0;
      end
      check("syn_valid", 48'(syn_valid), 48'(exp_sv));
      check("sop_err", 48'(sop_err), 48'(exp_se));
      check("busy", 48'(busy), 48'((m_cnt != 0) || exp_sv));
      if (syn_valid && exp_sv) begin
         if (sb.size() == 0) check("sb_underflow", 48'(1), 48'(0));
         else                held = sb.pop_front();
      end
      check("syn", syn, held);
      check("err_detect", 48'(err_detect), 48'(|held));
      nsv = 1'b0;
      nse = 1'b0;
      if (rst_n && in_valid) begin
         if (in_sop) begin
            nse   = (m_cnt != 0);
            m_cnt = 1;
         end else if (m_cnt != 0) begin
            m_cnt++;
            if (m_cnt == NB) begin
               nsv   = 1'b1;
               m_cnt = 0;
            end
         end
      end
      exp_sv = nsv;
      exp_se = nse;
   end

   initial begin
      gexp[0] = 8'h01;
      for (int e = 1; e < NB; e++) gexp[e] = tb_mul(gexp[e-1], 8'h02);

      idle(3);
      rst_n = 1'b1;
      idle(2);

      // stray symbols without in_sop are ignored while idle
      send_sym(8'h77, 1'b0);
      send_sym(8'h33, 1'b0);
      idle(2);

      fill_blk(8'h00);
      send_block(0, NB);
      idle(3);

      encode_msg();
      send_block(0, NB);
      idle(3);

      fill_blk(8'h00);
      blk[0] = 8'h01;
      send_block(0, NB);
      idle(2);

      fill_blk(8'h00);
      blk[NB-1] = 8'h5A;
      send_block(0, NB);
      idle(2);

      encode_msg();
      send_block(5, NB);
      idle(2);

      // back-to-back: clean codeword then a corrupted one, no bubble
      encode_msg();
      send_block(0, NB);
      blk[37] = blk[37] ^ 8'hC3;
      send_block(0, NB);
      idle(3);

      // early in_sop at symbol 100 restarts the block
      fill_rand();
      send_block(0, 100);
      encode_msg();
      blk[200] = blk[200] ^ 8'h11;
      send_block(0, NB);
      idle(3);

      // reset in the middle of a block
      fill_rand();
      send_block(0, 150);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      fill_rand();
      send_block(2, NB);
      idle(5);

      check("sb_empty", 48'(sb.size()), 48'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rs_syndrome.md
# rs_syndrome

RS(255,249) syndrome calculator over GF(2^8) for the decoder side of the Reed-Solomon link. It sits directly downstream of the encoder's codeword output (or the channel after it) and consumes one 8-bit code symbol per cycle, highest-degree coefficient first: 249 message symbols, then 6 parity symbols. After the 255th symbol it presents the six syndromes S0..S5 and an error-detect flag to the downstream key-equation solver.

## Interface
Parameters:
- FCR, 0: first consecutive root exponent; syndromes are S_i = C(alpha^(FCR+i)), i = 0..5.
- N, 255: code symbols per block.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_sym is a code symbol this cycle.
- in_sop  in  1  qualifies in_valid; marks the first symbol (degree 254) of a block.
- in_sym  in  8  code symbol.
- busy  out  1  block accumulation in progress.
- syn_valid  out  1  one-cycle pulse; syn and err_detect are new.
- syn  out  48  {S5,S4,S3,S2,S1,S0}, S0 in bits [7:0]; held until next syn_valid.
- err_detect  out  1  OR of all syndrome bits; held with syn.
- sop_err  out  1  one-cycle pulse: block aborted by an early in_sop.

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Horner accumulation per syndrome: acc_i <= gfmul(acc_i, alpha^(FCR+i)) ^ in_sym on each accepted symbol; first symbol (in_sop) loads acc_i <= in_sym.
- FSM states: IDLE, ACC.
  - IDLE: in_valid & in_sop -> load accumulators, cnt = 1, go ACC. in_valid without in_sop ignored.
  - ACC: in_valid & ~in_sop -> accumulate, cnt++. When the accepted symbol makes cnt == N: copy accumulator results to syn, pulse syn_valid next cycle, go IDLE.
  - ACC: in_valid & in_sop -> pulse sop_err, discard partial block, restart with this symbol as first (cnt = 1, stay ACC). syn unchanged.
- in_valid low: accumulators and cnt hold; gaps of any length allowed.
- cnt: 8-bit, range 0..255; never wraps inside a block.
- Reset values: busy 0, syn_valid 0, syn 48'h0, err_detect 0, sop_err 0; FSM IDLE; cnt 0; accumulators 0.
- Reset mid-block: partial block lost, no syn_valid, no sop_err.

## Timing
- Latency: syn_valid rises in the cycle after the edge that accepted symbol 255.
- busy = 1 from the cycle after the in_sop accept until the cycle syn_valid pulses (inclusive of final accept edge).
- Back-to-back: in_sop may arrive the cycle immediately after the last symbol; syn output registers are separate from accumulators, so zero bubble between blocks.
- sop_err pulses in the cycle after the restarting in_sop edge.
- No backpressure; input always accepted.

## Structure
- Shared package rs_pkg: RS_N = 255, RS_K = 249, RS_NPAR = 6, GF_POLY = 9'h11D, alpha power constants alpha^0..alpha^7 used as Horner multipliers; same generator coefficients as the encoder so both sides agree.
- Sub-module: reuse the codebase's existing GF(2^8) `multiply` (A, B -> X), one instance per syndrome with constant B = alpha^(FCR+i).

## Test plan
- All-zero 255-symbol block -> syn = 0, err_detect 0, syn_valid exactly one cycle after last accept.
- Encoder output for message 1..249 (mod 256) fed directly, FCR 0 -> syn = 0, err_detect 0.
- All-zero block with first symbol 0x01 -> S0 = 0x01, S1 = 0x8E (alpha^254), err_detect 1; last symbol 0x5A instead -> all S_i = 0x5A.
- Same encoder block with random 1-5 cycle in_valid gaps -> syndromes identical to gapless run; two blocks back-to-back -> two syn_valid pulses 255 cycles apart.
- in_sop at symbol 100 -> sop_err pulse, no syn_valid until 255 symbols after the restart, result matches restarted block alone.
- rst_n low at symbol 150 -> all outputs 0 immediately, no syn_valid; next full block correct.
